// File: rtl/router_pkg.sv
// Shared definitions for the mesh router forwarding stages (east and west paths).
// Packets carry a signed horizontal hop offset dx in the top nibble.
package router_pkg;

    localparam int PKT_W  = 16;
    localparam int DX_MSB = 15;
    localparam int DX_LSB = 12;

    typedef logic signed [DX_MSB-DX_LSB:0] dx_t;

    function automatic dx_t get_dx(input logic [PKT_W-1:0] pkt);
        return dx_t'(pkt[DX_MSB:DX_LSB]);
    endfunction

    function automatic logic [PKT_W-1:0] set_dx(input logic [PKT_W-1:0] pkt, input dx_t dx);
        logic [PKT_W-1:0] res;
        res                = pkt;
        res[DX_MSB:DX_LSB] = dx;
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/forward_east_buf.sv
// East-bound forwarding stage: positive dx goes east (decremented), zero dx goes to the
// local hand-off register, negative dx is dropped and counted.
module forward_east_buf
    import router_pkg::dx_t;
    import router_pkg::get_dx;
    import router_pkg::set_dx;
#(
    parameter int DEPTH = 4,
    parameter int PKT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PKT_W-1:0]        packet_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [PKT_W-1:0]        packet_east,
    output logic                    valid_east,
    input  logic                    ready_east,
    output logic [PKT_W-1:0]        packet_local,
    output logic                    valid_local,
    input  logic                    ready_local,
    output logic [$clog2(DEPTH):0]  east_count,
    output logic                    err_dx,
    output logic [7:0]              err_count
);

    dx_t            dx;
    logic           accept;
    logic           dx_pos;
    logic           dx_zero;
    logic           dx_neg;
    logic           fifo_empty;
    logic           fifo_full;
    logic [PKT_W-1:0] east_pkt;

    assign dx      = get_dx(packet_in);
    assign dx_neg  = dx[$bits(dx_t)-1];
    assign dx_zero = (dx == '0);
    assign dx_pos  = !dx_neg && !dx_zero;

    // Input stalls on any full path, independent of dx, so ready never depends on packet_in.
    assign ready_in = !fifo_full && !valid_local;
    assign accept   = valid_in && ready_in;

    // dx >= 1 here, so dx-1 lies in 0..6 and cannot wrap.
    assign east_pkt   = set_dx(packet_in, dx_t'(dx - dx_t'(1)));
    assign valid_east = !fifo_empty;

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_east_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && dx_pos),
        .pop   (ready_east),
        .din   (east_pkt),
        .dout  (packet_east),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (east_count)
    );

    // Load and pop cannot coincide: ready_in is low while the register is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_local  <= 1'b0;
            packet_local <= '0;
        end else if (accept && dx_zero) begin
            valid_local  <= 1'b1;
            packet_local <= packet_in;
        end else if (valid_local && ready_local) begin
            valid_local  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_dx    <= 1'b0;
            err_count <= '0;
        end else begin
            err_dx <= accept && dx_neg;
            if (accept && dx_neg && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_forward_east_buf.sv
// Directed bench for forward_east_buf: inputs driven and outputs sampled on the falling edge.
module tb_forward_east_buf;

    logic        clk;
    logic        rst;
    logic [15:0] packet_in;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] packet_east;
    logic        valid_east;
    logic        ready_east;
    logic [15:0] packet_local;
    logic        valid_local;
    logic        ready_local;
    logic [2:0]  east_count;
    logic        err_dx;
    logic [7:0]  err_count;

    int total;
    int bad;

    forward_east_buf #(
        .DEPTH (4),
        .PKT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .packet_in    (packet_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .packet_east  (packet_east),
        .valid_east   (valid_east),
        .ready_east   (ready_east),
        .packet_local (packet_local),
        .valid_local  (valid_local),
        .ready_local  (ready_local),
        .east_count   (east_count),
        .err_dx       (err_dx),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one packet for exactly one rising edge, returning on the following falling edge.
    task automatic applyStimulus(input logic [15:0] pkt);
        packet_in = pkt;
        valid_in  = 1'b1;
        @(negedge clk);
        valid_in  = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        packet_in   = '0;
        valid_in    = 1'b0;
        ready_east  = 1'b0;
        ready_local = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_valid_east", valid_east, 0);
        checkOutput("rst_count", east_count, 0);
        checkOutput("rst_valid_local", valid_local, 0);
        checkOutput("rst_packet_local", packet_local, 0);
        checkOutput("rst_packet_east", packet_east, 0);
        checkOutput("rst_err_dx", err_dx, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_ready_in", ready_in, 1);

        // Basic east forward
        applyStimulus(16'h3A5C);
        checkOutput("east1_pkt", packet_east, 16'h2A5C);
        checkOutput("east1_valid", valid_east, 1);
        checkOutput("east1_count", east_count, 1);
        ready_east = 1'b1;
        @(negedge clk);
        ready_east = 1'b0;
        checkOutput("east1_drained", valid_east, 0);

        // dx = +7 boundary
        applyStimulus(16'h7FFF);
        checkOutput("dx7_pkt", packet_east, 16'h6FFF);
        ready_east = 1'b1;
        @(negedge clk);
        ready_east = 1'b0;
        checkOutput("dx7_count", east_count, 0);

        // Local hold with backpressure
        applyStimulus(16'h0123);
        for (int i = 0; i < 3; i++) begin
            checkOutput("local_valid", valid_local, 1);
            checkOutput("local_pkt", packet_local, 16'h0123);
            checkOutput("local_ready_in", ready_in, 0);
            checkOutput("local_no_east", valid_east, 0);
            @(negedge clk);
        end
        ready_local = 1'b1;
        @(negedge clk);
        ready_local = 1'b0;
        checkOutput("local_popped", valid_local, 0);
        checkOutput("local_ready_back", ready_in, 1);

        // Fill east FIFO with dx=+1 packets under backpressure
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill_ready", ready_in, 1);
            applyStimulus(16'h1A00 + 16'(i));
        end
        checkOutput("full_count", east_count, 4);
        checkOutput("full_ready_in", ready_in, 0);
        // Offered while full: must be ignored
        applyStimulus(16'h1BBB);
        checkOutput("full_ignored", east_count, 4);
        ready_east = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", valid_east, 1);
            checkOutput("drain_pkt", packet_east, 16'h0A00 + 16'(i));
            @(negedge clk);
        end
        ready_east = 1'b0;
        checkOutput("drain_empty", valid_east, 0);
        checkOutput("drain_count", east_count, 0);

        // Negative dx drop and saturating error counter
        applyStimulus(16'hF000);
        checkOutput("err_pulse", err_dx, 1);
        checkOutput("err_count1", err_count, 1);
        checkOutput("err_no_east", valid_east, 0);
        checkOutput("err_no_local", valid_local, 0);
        @(negedge clk);
        checkOutput("err_pulse_end", err_dx, 0);
        applyStimulus(16'h8000);
        checkOutput("err_dx_m8", err_count, 2);
        packet_in = 16'hF000;
        valid_in  = 1'b1;
        repeat (252) @(negedge clk);
        checkOutput("err_count254", err_count, 254);
        @(negedge clk);
        checkOutput("err_count255", err_count, 255);
        repeat (47) @(negedge clk);
        valid_in = 1'b0;
        checkOutput("err_sat", err_count, 255);
        checkOutput("err_sat_no_east", valid_east, 0);

        // Steady state: two entries, push and pop every cycle
        applyStimulus(16'h2100);
        applyStimulus(16'h2101);
        checkOutput("stream_pre_count", east_count, 2);
        ready_east = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("stream_count", east_count, 2);
            checkOutput("stream_pkt", packet_east, 16'h1100 + 16'(k));
            checkOutput("stream_ready", ready_in, 1);
            packet_in = 16'h2102 + 16'(k);
            valid_in  = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        for (int k = 10; k < 12; k++) begin
            checkOutput("stream_tail", packet_east, 16'h1100 + 16'(k));
            @(negedge clk);
        end
        ready_east = 1'b0;
        checkOutput("stream_empty", east_count, 0);

        // Reset mid-operation with both paths occupied
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h4000 + 16'(i));
        end
        applyStimulus(16'h0ABC);
        checkOutput("pre_rst_count", east_count, 3);
        checkOutput("pre_rst_local", valid_local, 1);
        checkOutput("pre_rst_ready", ready_in, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_valid_east", valid_east, 0);
        checkOutput("mid_rst_valid_local", valid_local, 0);
        checkOutput("mid_rst_count", east_count, 0);
        checkOutput("mid_rst_ready", ready_in, 1);
        checkOutput("mid_rst_err_count", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
